smi_axi_slave_read_bridge: RTL
==============================

Name: smi_axi_slave_read_bridge

Overview:
- AXI-4 read slave that converts each incoming AR burst into an SMI read request frame, then returns the matching SMI read response frame as AXI R beats.
- It is the reverse of the SMI-to-AXI memory adaptor. An AXI master, such as a host DMA or a soft CPU, can read memory reached through the SMI fabric.
- Only one transaction is in flight at a time. The 64-bit flit / data width is fixed.

Parameters:
AxiIdWidth, 4, width of axiARId/axiRId (1..8)
CacheInsert, 0, reserved; must be 0; no buffering beyond the state machine

Ports:
clk  input  1  clock
srst  input  1  synchronous active-high reset
axiARValid  input  1  AR valid
axiARReady  output  1  AR ready
axiARId  input  AxiIdWidth  AR transaction ID
axiARAddr  input  64  AR byte address
axiARLen  input  8  beats minus one
axiARSize  input  3  beat size; ignored, treated as 3 (8 bytes)
axiRValid  output  1  R valid
axiRReady  input  1  R ready
axiRId  output  AxiIdWidth  R ID, equal to the latched ARId
axiRData  output  64  R data
axiRResp  output  2  R response
axiRLast  output  1  last beat
smiReqReady  output  1  request flit valid
smiReqEofc  output  8  request end-of-frame count
smiReqData  output  64  request flit
smiReqStop  input  1  request backpressure
smiRespReady  input  1  response flit valid
smiRespEofc  input  8  response end-of-frame count
smiRespData  input  64  response flit
smiRespStop  output  1  response backpressure

Behaviour:
- SMI transfer rule: a flit transfers on a cycle with Ready=1 and Stop=0. Eofc=0 means mid-frame; Eofc=1..8 marks the last flit and gives its valid byte count.
- AXI transfer rule: standard VALID&&READY.
- Reset values: axiARReady=0, axiRValid=0, axiRLast=0, axiRResp=0, axiRData=0, axiRId=0, smiReqReady=0, smiReqEofc=0, smiReqData=0, smiRespStop=1. State goes to IDLE.
- srst mid-transaction abandons the transaction. No R beats are emitted for it afterwards.
- States: IDLE, REQ0, REQ1, RHDR, RDATA, RPAD, DRAIN.
- IDLE:
  - axiARReady=1 one cycle after srst deasserts, and whenever in IDLE.
  - On an AR handshake, latch ID, Addr and Len, clear the beat counter, and go to REQ0.
- REQ0 (registered outputs, first cycle after the handshake):
  - smiReqReady=1, smiReqEofc=0.
  - smiReqData = {Addr[31:0], byteLen[15:0], tag[7:0], 8'h02}.
  - byteLen = (Len+1)*8, range 8..2048.
  - tag = ID zero-extended to 8 bits.
  - Hold until transferred, then go to REQ1.
- REQ1:
  - smiReqData = {32'h0, Addr[63:32]}, smiReqEofc=8.
  - Hold until transferred. On transfer, drop smiReqReady the next cycle and go to RHDR.
- RHDR:
  - smiRespStop=0. Accept one header flit and latch status = data[17:16].
  - Header tag byte [15:8] is not checked; transactions are serialised.
  - Header Eofc!=0 (frame has no data): go to RPAD with forced SLVERR.
  - Otherwise go to RDATA.
- RDATA (combinational pass-through):
  - axiRValid = smiRespReady.
  - axiRData = smiRespData.
  - axiRResp = status.
  - axiRLast = (beat==Len).
  - smiRespStop = !axiRReady.
  - The beat counter increments on each transfer.
- RDATA end conditions:
  - Last beat with Eofc!=0: go to IDLE (normal end).
  - Last beat with Eofc==0 (frame too long): go to DRAIN.
  - Non-last beat with Eofc!=0 (frame too short): go to RPAD with forced SLVERR.
- RPAD:
  - smiRespStop=1, axiRValid=1, axiRData=0, axiRResp=2'b10.
  - Emit the remaining beats to the Len count with RLast on the final one, then go to IDLE.
- DRAIN:
  - smiRespStop=0, axiRValid=0. Discard flits until one with Eofc!=0 transfers, then go to IDLE.
- A beat on which axiRLast=1 is never followed by another R beat for that ID.
- axiARReady=0 in every non-IDLE state.
- Len=0 is legal: one data beat, with RLast on that beat.
- Len=255: byteLen=2048; the 8-bit beat counter must not wrap before the compare.
- Between a frame's end and the return to IDLE, any unrelated response flit is held off by smiRespStop=1.
- Request-path latency: AR handshake to first smiReqReady = 1 cycle.
- Back-to-back: a new AR is accepted one cycle after the previous RLast transfer.

Test Plan:
- AR ID=3, Addr=0x0000_0001_2345_6780, Len=3, no stalls.
  - Required: flit0 = 0x23456780_0020_03_02, flit1 = 0x00000000_00000001 with Eofc=8.
  - Then the response header (status 0) plus 4 data flits, the last with Eofc=8.
  - Required: 4 R beats with ID 3, data identical, RResp=0, RLast only on beat 3, then axiARReady=1.
- Random smiReqStop / axiRReady / smiRespReady stalls on a Len=15 burst. Required:
  - The request flits hold stable while stopped.
  - No data is lost or duplicated.
  - smiRespStop equals !axiRReady in RDATA.
- Response header status=2'b10 with Len=1. Required: both beats carry RResp=2'b10.
- Short frame: Len=3, Eofc=8 on data flit 1. Required:
  - Beats 0-1 pass through with status.
  - Beats 2-3 have data 0, RResp=2'b10, RLast on beat 3.
- Long frame: Len=0, 3 data flits. Required:
  - One R beat with RLast.
  - Two flits drained with axiRValid=0.
  - Next AR accepted only after the Eofc!=0 flit.
- srst asserted while in RDATA after 2 of 8 beats. Required:
  - Next cycle all outputs are at their reset values and smiRespStop=1.
  - A fresh AR after reset completes normally.

Source files
------------

// File: rtl/smi_axi_slave_read_bridge.sv
// rtl/smi_axi_slave_read_bridge.sv - AXI4 read slave turning AR bursts into SMI read frames and SMI responses into R beats
module smi_axi_slave_read_bridge #(
    parameter int AxiIdWidth  = 4,
    parameter int CacheInsert = 0
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  axiARValid,
    output logic                  axiARReady,
    input  logic [AxiIdWidth-1:0] axiARId,
    input  logic [63:0]           axiARAddr,
    input  logic [7:0]            axiARLen,
    input  logic [2:0]            axiARSize,
    output logic                  axiRValid,
    input  logic                  axiRReady,
    output logic [AxiIdWidth-1:0] axiRId,
    output logic [63:0]           axiRData,
    output logic [1:0]            axiRResp,
    output logic                  axiRLast,
    output logic                  smiReqReady,
    output logic [7:0]            smiReqEofc,
    output logic [63:0]           smiReqData,
    input  logic                  smiReqStop,
    input  logic                  smiRespReady,
    input  logic [7:0]            smiRespEofc,
    input  logic [63:0]           smiRespData,
    output logic                  smiRespStop
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        REQ1  = 3'd2,
        RHDR  = 3'd3,
        RDATA = 3'd4,
        RPAD  = 3'd5,
        DRAIN = 3'd6
    } state_t;

    state_t                  state;
    logic [AxiIdWidth-1:0]   id_q;
    logic [63:0]             addr_q;
    logic [7:0]              len_q;
    logic [7:0]              beat;
    logic [1:0]              status;
    logic                    ar_ready_q;
    logic                    req_ready_q;
    logic [7:0]              req_eofc_q;
    logic [63:0]             req_data_q;
    logic                    last_beat;
    logic                    resp_end;
    logic [15:0]             byte_len;
    logic                    unused_bits;

    // Burst size is fixed at 8 bytes, so ARSize carries no information.
    assign unused_bits = ^{axiARSize, 1'(CacheInsert)};

    assign last_beat   = (beat == len_q);
    assign resp_end    = (smiRespEofc != 8'd0);
    assign byte_len    = 16'({axiARLen, 3'b000}) + 16'd8;

    assign axiARReady  = ar_ready_q;
    assign smiReqReady = req_ready_q;
    assign smiReqEofc  = req_eofc_q;
    assign smiReqData  = req_data_q;
    assign axiRId      = id_q;

    // The response path is a combinational pass-through so a data flit costs no extra cycle.
    always_comb begin
        axiRValid   = 1'b0;
        axiRData    = 64'h0;
        axiRResp    = 2'b00;
        axiRLast    = 1'b0;
        smiRespStop = 1'b1;
        case (state)
            RHDR: smiRespStop = 1'b0;
            RDATA: begin
                axiRValid   = smiRespReady;
                axiRData    = smiRespData;
                axiRResp    = status;
                axiRLast    = last_beat;
                smiRespStop = !axiRReady;
            end
            RPAD: begin
                axiRValid = 1'b1;
                axiRResp  = 2'b10;
                axiRLast  = last_beat;
            end
            DRAIN: smiRespStop = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= IDLE;
            id_q        <= '0;
            addr_q      <= 64'h0;
            len_q       <= 8'h0;
            beat        <= 8'h0;
            status      <= 2'b00;
            ar_ready_q  <= 1'b0;
            req_ready_q <= 1'b0;
            req_eofc_q  <= 8'h0;
            req_data_q  <= 64'h0;
        end else begin
            case (state)
                IDLE: begin
                    ar_ready_q <= 1'b1;
                    if (ar_ready_q && axiARValid) begin
                        id_q        <= axiARId;
                        addr_q      <= axiARAddr;
                        len_q       <= axiARLen;
                        beat        <= 8'h0;
                        ar_ready_q  <= 1'b0;
                        req_ready_q <= 1'b1;
                        req_eofc_q  <= 8'h0;
                        req_data_q  <= {axiARAddr[31:0], byte_len, 8'(axiARId), 8'h02};
                        state       <= REQ0;
                    end
                end
                REQ0: if (!smiReqStop) begin
                    req_data_q <= {32'h0, addr_q[63:32]};
                    req_eofc_q <= 8'd8;
                    state      <= REQ1;
                end
                REQ1: if (!smiReqStop) begin
                    req_ready_q <= 1'b0;
                    req_eofc_q  <= 8'h0;
                    req_data_q  <= 64'h0;
                    state       <= RHDR;
                end
                RHDR: if (smiRespReady) begin
                    // A header that already ends the frame carries no data at all.
                    status <= resp_end ? 2'b10 : smiRespData[17:16];
                    state  <= resp_end ? RPAD : RDATA;
                end
                RDATA: if (smiRespReady && axiRReady) begin
                    beat <= beat + 8'd1;
                    if (last_beat) begin
                        if (resp_end) begin
                            ar_ready_q <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (resp_end) begin
                        status <= 2'b10;
                        state  <= RPAD;
                    end
                end
                RPAD: if (axiRReady) begin
                    beat <= beat + 8'd1;
                    if (last_beat) begin
                        ar_ready_q <= 1'b1;
                        state      <= IDLE;
                    end
                end
                DRAIN: if (smiRespReady && resp_end) begin
                    ar_ready_q <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
